div_sched: RTL and testbench

Sequencer between the EX stage and the shared iterative divider behind the ALU's div/mod ops. It registers one request, short-circuits the special cases, and drives the divider's level-enable until it finishes. It then holds the selected quotient or remainder behind a valid/ready response and can cancel on pipeline flush.

---
 rtl/div_sched_if.sv | 37 +++
 rtl/div_sched.sv | 150 +++++++++++++++
 tb/tb_div_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_sched_if.sv
// div_sched_if: request/response and divider-side signals of the div/mod sequencer.
// The slave modport is the sequencer's view. The master modport is the
// environment's view (EX stage, consumer and iterative divider).
interface div_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic        req_mod;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        flush;
    logic        busy;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_done;
    logic [31:0] div_s;
    logic [31:0] div_r;

    modport slave (
        input  req_valid, req_signed, req_mod, req_x, req_y, resp_ready, flush,
               div_done, div_s, div_r,
        output req_ready, resp_valid, resp_result, busy, div_en, div_signed,
               div_x, div_y
    );

    modport master (
        output req_valid, req_signed, req_mod, req_x, req_y, resp_ready, flush,
               div_done, div_s, div_r,
        input  req_ready, resp_valid, resp_result, busy, div_en, div_signed,
               div_x, div_y
    );
endinterface

// File: rtl/div_sched.sv
// div_sched: sequencer between EX and the shared iterative divider.
// It registers one request and resolves divide-by-zero and signed overflow
// locally. Other requests run the divider under a level enable, and the
// selected quotient/remainder is held behind a valid/ready response.
// A flush cancels any in-flight operation.
// Optional: define DIV_SCHED_CACHE_EN for a one-entry result cache.
module div_sched (
    input  logic           clk,
    input  logic           resetn,
    div_sched_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        sgn_q, sgn_d;
    logic        mod_q, mod_d;
    logic        en_q, en_d;

    logic        accept;
    logic        y_zero;
    logic        ovf;
    logic [31:0] special_res;
    logic        cache_hit;
    logic [31:0] cache_res;
    logic        fill;

    // A flushing cycle never accepts, so a cancelled request leaves no trace.
    assign accept = bus.req_valid && (state_q == S_IDLE) && !bus.flush;

    // Special cases are resolved without the divider.
    assign y_zero      = (bus.req_y == 32'h0);
    assign ovf         = bus.req_signed && (bus.req_x == 32'h8000_0000)
                         && (bus.req_y == 32'hFFFF_FFFF);
    assign special_res = y_zero ? (bus.req_mod ? bus.req_x : 32'hFFFF_FFFF)
                                : (bus.req_mod ? 32'h0 : 32'h8000_0000);

    // The cache is written only by a completed, unflushed divider run.
    assign fill = (state_q == S_RUN) && bus.div_done && !bus.flush;

`ifdef DIV_SCHED_CACHE_EN
    logic        cvld_q;
    logic        csgn_q;
    logic [31:0] cx_q, cy_q, cs_q, cr_q;

    assign cache_hit = cvld_q && (cx_q == bus.req_x) && (cy_q == bus.req_y)
                       && (csgn_q == bus.req_signed);
    assign cache_res = bus.req_mod ? cr_q : cs_q;

    // Cache entry: only reset invalidates it. A flush leaves it intact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cvld_q <= 1'b0;
            csgn_q <= 1'b0;
            cx_q   <= '0;
            cy_q   <= '0;
            cs_q   <= '0;
            cr_q   <= '0;
        end else if (fill) begin
            cvld_q <= 1'b1;
            csgn_q <= sgn_q;
            cx_q   <= x_q;
            cy_q   <= y_q;
            cs_q   <= bus.div_s;
            cr_q   <= bus.div_r;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = 32'h0;
    logic unused_fill;
    assign unused_fill = fill;
`endif

    // Next-state, operand latch and result selection.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        x_d      = x_q;
        y_d      = y_q;
        sgn_d    = sgn_q;
        mod_d    = mod_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (y_zero || ovf) begin
                        state_d  = S_RESP;
                        result_d = special_res;
                    end else if (cache_hit) begin
                        state_d  = S_RESP;
                        result_d = cache_res;
                    end else begin
                        state_d = S_RUN;
                        x_d     = bus.req_x;
                        y_d     = bus.req_y;
                        sgn_d   = bus.req_signed;
                        mod_d   = bus.req_mod;
                    end
                end
            end
            S_RUN: begin
                if (bus.div_done) begin
                    state_d  = S_RESP;
                    result_d = mod_q ? bus.div_r : bus.div_s;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        en_d = (state_d == S_RUN);
    end

    // State and datapath registers; reset drops div_en immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sgn_q    <= 1'b0;
            mod_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sgn_q    <= sgn_d;
            mod_q    <= mod_d;
            en_q     <= en_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.resp_valid  = (state_q == S_RESP);
    assign bus.resp_result = result_q;
    assign bus.busy        = en_q;
    assign bus.div_en      = en_q;
    assign bus.div_signed  = sgn_q;
    assign bus.div_x       = x_q;
    assign bus.div_y       = y_q;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed vectors plus hand-written multi-cycle sequences.
// The divider model completes a fixed LAT cycles after div_en rises.
module tb_div_sched;
    localparam int LAT = 17;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    div_sched_if bus();

    div_sched dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Divider model: count enabled cycles and pulse done with the reference result.
    int   cnt = 0;
    logic mdone = 1'b0;
    logic spur = 1'b0;
    always @(negedge clk) begin
        mdone = 1'b0;
        if (bus.div_en) begin
            cnt = cnt + 1;
            if (cnt == LAT) begin
                mdone = 1'b1;
                if (bus.div_y == 32'h0) begin
                    bus.div_s = 32'hFFFF_FFFF;
                    bus.div_r = bus.div_x;
                end else if (bus.div_signed) begin
                    bus.div_s = $signed(bus.div_x) / $signed(bus.div_y);
                    bus.div_r = $signed(bus.div_x) % $signed(bus.div_y);
                end else begin
                    bus.div_s = bus.div_x / bus.div_y;
                    bus.div_r = bus.div_x % bus.div_y;
                end
            end
        end else begin
            cnt = 0;
        end
        bus.div_done = mdone | spur;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request; called just after a rising edge with req_ready high.
    task automatic issue(input bit s, input bit m, input logic [31:0] x, input logic [31:0] y);
        bus.req_valid  = 1'b1;
        bus.req_signed = s;
        bus.req_mod    = m;
        bus.req_x      = x;
        bus.req_y      = y;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    // Count samples until resp_valid; div_en must be high on every one of them.
    task automatic wait_resp(output int n, output bit en_ok);
        n = 0;
        en_ok = 1'b1;
        while (!bus.resp_valid && n < 100) begin
            if (!(bus.div_en && bus.busy)) en_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    typedef struct {
        bit          s;
        bit          m;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        bit          fast;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int  n;
        bit  en_ok;
        bit  stay;

        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_mod    = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.resp_ready = 1'b1;
        bus.flush      = 1'b0;

        vecs[0]  = '{1, 0, 32'd7,          32'd2,          32'd3,          0};
        vecs[1]  = '{1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0};
        vecs[2]  = '{0, 0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[3]  = '{0, 1, 32'd5,          32'd0,          32'd5,          1};
        vecs[4]  = '{1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[5]  = '{1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
        vecs[6]  = '{0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          0};
        vecs[7]  = '{0, 0, 32'd100,        32'd7,          32'd14,         0};
`ifdef DIV_SCHED_CACHE_EN
        vecs[8]  = '{0, 1, 32'd100,        32'd7,          32'd2,          1};
`else
        vecs[8]  = '{0, 1, 32'd100,        32'd7,          32'd2,          0};
`endif
        vecs[9]  = '{1, 0, 32'd100,        32'd7,          32'd14,         0};
        vecs[10] = '{1, 1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  0};

        // Reset state.
        #1;
        chk("rst_req_ready",  {31'h0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("rst_resp_result", bus.resp_result,        32'd0);
        chk("rst_busy",       {31'h0, bus.busy},       32'd0);
        chk("rst_div_en",     {31'h0, bus.div_en},     32'd0);
        chk("rst_div_signed", {31'h0, bus.div_signed}, 32'd0);
        chk("rst_div_x",      bus.div_x,               32'd0);
        chk("rst_div_y",      bus.div_y,               32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Table of single requests, consumer always ready.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].s, vecs[i].m, vecs[i].x, vecs[i].y);
            wait_resp(n, en_ok);
            if (vecs[i].fast) begin
                chk($sformatf("v%0d_latency", i), n, 0);
            end else begin
                chk($sformatf("v%0d_latency", i), n, LAT);
                chk($sformatf("v%0d_div_en_run", i), {31'h0, en_ok}, 32'd1);
            end
            chk($sformatf("v%0d_result", i), bus.resp_result, vecs[i].res);
            chk($sformatf("v%0d_div_en_resp", i), {31'h0, bus.div_en}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", i), {30'h0, bus.req_ready, bus.resp_valid}, 32'd2);
        end

        // Flush 5 cycles into a run: divider aborted, no response.
        issue(0, 0, 32'd50, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_div_en", {31'h0, bus.div_en}, 32'd0);
        chk("flush_ready",  {31'h0, bus.req_ready}, 32'd1);
        stay = 1'b0;
        repeat (25) begin
            if (bus.resp_valid || bus.div_en) stay = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_quiet", {31'h0, stay}, 32'd0);
        // Flushed operands must not have reached the cache.
        issue(0, 0, 32'd50, 32'd3);
        wait_resp(n, en_ok);
        chk("flushed_ops_miss", n, LAT);
        chk("flushed_ops_res",  bus.resp_result, 32'd16);
        @(posedge clk); #1;
        issue(0, 0, 32'd9, 32'd4);
        wait_resp(n, en_ok);
        chk("after_flush_lat", n, LAT);
        chk("after_flush_res", bus.resp_result, 32'd2);
        @(posedge clk); #1;

        // Flush in the same cycle as a request: nothing is accepted.
        bus.flush = 1'b1;
        issue(0, 0, 32'd5, 32'd0);
        bus.flush = 1'b0;
        chk("flush_accept", {30'h0, bus.resp_valid, bus.div_en}, 32'd0);
        chk("flush_accept_ready", {31'h0, bus.req_ready}, 32'd1);

        // Flush while a response waits: resp_valid drops.
        bus.resp_ready = 1'b0;
        issue(0, 0, 32'd5, 32'd0);
        chk("resp_wait_valid", {31'h0, bus.resp_valid}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_resp_valid", {31'h0, bus.resp_valid}, 32'd0);

        // Back-pressure: result held stable for 3 cycles, handshake on the 4th.
        issue(1, 0, 32'd7, 32'd2);
        wait_resp(n, en_ok);
        stay = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!bus.resp_valid || bus.resp_result !== 32'd3 || bus.req_ready) stay = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_stable", {31'h0, stay}, 32'd0);
        chk("bp_result", bus.resp_result, 32'd3);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", {30'h0, bus.req_ready, bus.resp_valid}, 32'd2);

        // Reset in the middle of a run.
        issue(0, 0, 32'd1000, 32'd9);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_div_en", {31'h0, bus.div_en}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_div_en",  {31'h0, bus.div_en},     32'd0);
        chk("mid_rst_busy",    {31'h0, bus.busy},       32'd0);
        chk("mid_rst_ready",   {31'h0, bus.req_ready},  32'd1);
        chk("mid_rst_valid",   {31'h0, bus.resp_valid}, 32'd0);
        chk("mid_rst_result",  bus.resp_result,         32'd0);
        chk("mid_rst_div_x",   bus.div_x,               32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        stay = 1'b0;
        repeat (4) begin
            if (bus.resp_valid || bus.div_en) stay = 1'b1;
            @(posedge clk); #1;
        end
        chk("spurious_done", {31'h0, stay}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
